// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with private HI/LO result registers.
// The result is computed from the operands sampled on the start edge and
// parked in a pending register; it is committed to HI/LO once the fixed
// latency (MULT_CYCLES or DIV_CYCLES) has elapsed.
// Optional feature: define MDU_MADD_EN to enable MADD (op 7) and MSUB (op 8),
// which accumulate a signed product into {hi,lo}. Without it, ops 7/8 are NOPs.
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,   // must be >= 1
  parameter int DIV_CYCLES  = 10   // must be >= 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       mdu_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int DW         = 2 * WIDTH;
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [WIDTH-1:0] W_ONE     = WIDTH'(1);

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MSUB  = 4'd8
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0]  pend_lo_q, pend_lo_d;
  logic              pend_wr_q, pend_wr_d;
  logic              is_multi;

  // ---------------------------------------------------------------------------
  // Arithmetic, evaluated on the live operands so the result is ready on the
  // start edge.
  // ---------------------------------------------------------------------------
  logic [DW-1:0]    a_sx, b_sx, a_zx, b_zx;
  logic [DW-1:0]    prod_s, prod_u;

  assign a_sx   = {{WIDTH{A[WIDTH-1]}}, A};
  assign b_sx   = {{WIDTH{B[WIDTH-1]}}, B};
  assign a_zx   = {{WIDTH{1'b0}}, A};
  assign b_zx   = {{WIDTH{1'b0}}, B};
  // Low DW bits of the sign-extended product are the exact signed product.
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  logic             b_zero, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, b_div_u;
  logic [WIDTH-1:0] uq, ur, sq_mag, sr_mag, sq, sr;

  assign b_zero  = (B == '0);
  assign a_neg   = A[WIDTH-1];
  assign b_neg   = B[WIDTH-1];
  assign a_mag   = a_neg ? -A : A;
  // A zero divisor is replaced by one so the dividers never see x/0; the
  // result is discarded in that case anyway.
  assign b_div_u = b_zero ? W_ONE : B;
  assign b_mag   = b_zero ? W_ONE : (b_neg ? -B : B);

  assign uq      = A / b_div_u;
  assign ur      = A % b_div_u;
  assign sq_mag  = a_mag / b_mag;
  assign sr_mag  = a_mag % b_mag;
  // Quotient truncates toward zero; remainder takes the dividend's sign.
  // MIN / -1 falls out naturally: |MIN| / 1 wraps back to MIN, remainder 0.
  assign sq      = (a_neg ^ b_neg) ? -sq_mag : sq_mag;
  assign sr      = a_neg ? -sr_mag : sr_mag;

`ifdef MDU_MADD_EN
  logic [DW-1:0] acc, madd_res, msub_res;

  assign acc      = {hi_q, lo_q};
  assign madd_res = acc + prod_s;
  assign msub_res = acc - prod_s;
`endif

  // Decode which operations occupy the unit for more than one cycle.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    is_multi = 1'b0;
    case (mdu_op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_multi = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MSUB:                   is_multi = 1'b1;
`endif
      default:                            is_multi = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave IDLE on a multi-cycle start, return when the count expires.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start && is_multi) state_d = S_RUN;
      S_RUN:   if (cnt_q == '0)       state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: busy follows the RUN state, stall also covers the start cycle.
  always_comb begin
    busy      = (state_q == S_RUN);
    stall_req = busy | (start & is_multi);
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------

  // Capture results on start, count down while running, commit on expiry.
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          case (mdu_op)
            OP_MULT: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_wr_d              = 1'b1;
              cnt_d                  = MULT_LOAD;
            end
            OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              pend_wr_d              = 1'b1;
              cnt_d                  = MULT_LOAD;
            end
            OP_DIV: begin
              pend_hi_d = sr;
              pend_lo_d = sq;
              pend_wr_d = ~b_zero;
              cnt_d     = DIV_LOAD;
            end
            OP_DIVU: begin
              pend_hi_d = ur;
              pend_lo_d = uq;
              pend_wr_d = ~b_zero;
              cnt_d     = DIV_LOAD;
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
              {pend_hi_d, pend_lo_d} = madd_res;
              pend_wr_d              = 1'b1;
              cnt_d                  = MULT_LOAD;
            end
            OP_MSUB: begin
              {pend_hi_d, pend_lo_d} = msub_res;
              pend_wr_d              = 1'b1;
              cnt_d                  = MULT_LOAD;
            end
`endif
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          pend_wr_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
